wb_slave_regfile: RTL and testbench
===================================

Name: wb_slave_regfile

Overview:
- Wishbone B4 pipelined slave (responder) exposing a small bank of 32-bit registers to the platform bus.
- Acts as the default target for the bus master transactor.
- Decodes the address, applies byte-select writes, and inserts a programmable number of wait states.
- Signals wb_err on illegal accesses; counts successful transactions for the testbench.

Parameters:
- BASE_ADDR, 32'h1000_0000, byte address of register 0.
- NUM_REGS, 8, number of 32-bit registers (2..256); register 0 is a read-only ID.
- WAIT_STATES, 1, extra cycles between accept and response (0..15).
- ID_VALUE, 32'hC0DE_0001, constant value returned by register 0.

Ports:
- wb_clk  in  1  bus clock; all logic on rising edge.
- wb_rst_n  in  1  asynchronous, active-low reset.
- wb_cyc  in  1  bus cycle valid from master.
- wb_stb  in  1  strobe/request from master.
- wb_we  in  1  1=write, 0=read.
- wb_sel  in  4  byte lane enables; bit i selects bits [8i+7:8i].
- wb_adr  in  32  byte address.
- wb_dat_i  in  32  write data from master.
- wb_dat_o  out  32  read data to master.
- wb_ack  out  1  successful termination, one-cycle pulse.
- wb_err  out  1  error termination, one-cycle pulse.
- wb_stall  out  1  slave cannot accept a new request.
- txn_count  out  32  number of acked transactions; wraps modulo 2^32.

Behaviour:
- Reset (async assert, sync release):
  - all registers 1..NUM_REGS-1 = 0; wb_dat_o = 0; wb_ack = 0; wb_err = 0; wb_stall = 0; txn_count = 0; FSM = IDLE.
- FSM states IDLE, WAIT, RESP. All outputs are registered.
- IDLE:
  - wb_stall = 0.
  - On an edge with wb_cyc & wb_stb: latch adr/we/sel/dat_i; load wait counter with WAIT_STATES; wb_stall <= 1.
  - Next state is WAIT if WAIT_STATES > 0, else RESP.
- WAIT:
  - wb_stall = 1; counter decrements each edge.
  - At counter == 1, the next state is RESP.
- RESP entry (single edge):
  - Evaluate the latched request.
  - Drive exactly one of wb_ack or wb_err high for exactly one cycle.
  - Read: wb_dat_o <= full 32-bit register word; sel does not mask read data.
  - Write: only selected bytes are updated, on the same edge ack is raised.
  - On ack, txn_count increments.
  - Next edge: ack/err drop, wb_stall <= 0, FSM = IDLE.
- Latency: request sampled at edge T0 -> ack/err high in the cycle following edge T0+1+WAIT_STATES.
  - WAIT_STATES=0 gives ack visible after T0+1.
  - Back-to-back throughput is one transaction per WAIT_STATES+3 cycles.
- Decode:
  - off = wb_adr - BASE_ADDR (32-bit unsigned; addresses below base wrap high and fail the range check).
  - idx = off[9:2].
- Error conditions (err instead of ack; no register change; wb_dat_o unchanged; txn_count unchanged):
  - off >= 4*NUM_REGS;
  - wb_adr[1:0] != 0;
  - wb_sel == 0;
  - write to idx 0.
- Register 0 read returns ID_VALUE.
- Abort: if wb_cyc drops while in WAIT or at RESP entry:
  - return to IDLE next edge;
  - no write, no ack/err, txn_count unchanged.
- wb_stb asserted while wb_stall=1 is ignored; the master must hold the request.
- Reset asserted mid-transaction: immediate return to reset values; the pending write is discarded.

Decomposition:
- Package wb_slave_pkg:
  - state enum (IDLE, WAIT, RESP);
  - WB_DW=32, WB_AW=32, WB_SELW=4 constants;
  - decode result struct {hit, misaligned, ro_violation, idx}.
- Sub-module wb_slave_decode: purely combinational address/error decode, parameterised by BASE_ADDR/NUM_REGS.
- FSM, register array and counters live in the top module.

Test Plan:
- Reset, then read 0x1000_0000 -> one-cycle ack, wb_dat_o=32'hC0DE_0001, txn_count=1; ack seen exactly 2 cycles after accept (WAIT_STATES=1).
- Write 0x1000_0008 data 32'hAABB_CCDD sel 4'b0101, then read it back -> read returns 32'h00BB_00DD; txn_count=2.
- Write 0x1000_0000 (ID), read 0x1000_0020 (out of range), read 0x1000_0006 (misaligned), write with sel=0 -> wb_err pulse each, no ack, txn_count unchanged, register contents unchanged.
- Issue request then hold wb_stb while wb_stall=1 -> only one transaction accepted; wb_stall deasserts the cycle after ack.
- Drop wb_cyc during WAIT of a write to 0x1000_0004 (data 32'h1234_5678) -> no ack/err; a later read of 0x1000_0004 returns 0.
- Assert wb_rst_n=0 asynchronously mid-WAIT after earlier writes -> outputs reset immediately, registers 0, txn_count 0; the first post-reset read behaves as in scenario 1.

Source files
------------

// File: rtl/wb_slave_regfile_pkg.sv
// Shared types and bus widths for the Wishbone register-file slave.
package wb_slave_pkg;

  localparam int unsigned WB_DW   = 32;
  localparam int unsigned WB_AW   = 32;
  localparam int unsigned WB_SELW = 4;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } wb_state_e;

  typedef struct packed {
    logic       hit;
    logic       misaligned;
    logic       ro_violation;
    logic [7:0] idx;
  } wb_decode_t;

endpackage

// File: rtl/wb_slave_regfile_if.sv
// Wishbone B4 pipelined bus signals between master transactor and register-file slave.
interface wb_slave_regfile_if
  import wb_slave_pkg::*;
();

  logic               wb_cyc;
  logic               wb_stb;
  logic               wb_we;
  logic [WB_SELW-1:0] wb_sel;
  logic [WB_AW-1:0]   wb_adr;
  logic [WB_DW-1:0]   wb_dat_i;
  logic [WB_DW-1:0]   wb_dat_o;
  logic               wb_ack;
  logic               wb_err;
  logic               wb_stall;

  modport master (
    output wb_cyc, wb_stb, wb_we, wb_sel, wb_adr, wb_dat_i,
    input  wb_dat_o, wb_ack, wb_err, wb_stall
  );

  modport slave (
    input  wb_cyc, wb_stb, wb_we, wb_sel, wb_adr, wb_dat_i,
    output wb_dat_o, wb_ack, wb_err, wb_stall
  );

endinterface

// File: rtl/wb_slave_regfile_decode.sv
// Combinational address decode: range hit, alignment and read-only checks.
module wb_slave_decode
  import wb_slave_pkg::*;
#(
  parameter logic [WB_AW-1:0] BASE_ADDR = 32'h1000_0000,
  parameter int unsigned      NUM_REGS  = 8
) (
  input  logic [WB_AW-1:0] adr,
  input  logic             we,
  output wb_decode_t       dec
);

  logic [WB_AW-1:0] off;

  // Addresses below the base wrap to large offsets and fail the range test.
  always_comb begin
    off              = adr - BASE_ADDR;
    dec.hit          = (off < WB_AW'(4 * NUM_REGS));
    dec.misaligned   = (adr[1:0] != 2'b00);
    dec.idx          = off[9:2];
    dec.ro_violation = we && dec.hit && (dec.idx == '0);
  end

endmodule

// File: rtl/wb_slave_regfile.sv
// Wishbone B4 pipelined register-file slave with programmable wait states.
module wb_slave_regfile
  import wb_slave_pkg::*;
#(
  parameter logic [WB_AW-1:0] BASE_ADDR   = 32'h1000_0000,
  parameter int unsigned      NUM_REGS    = 8,
  parameter int unsigned      WAIT_STATES = 1,
  parameter logic [WB_DW-1:0] ID_VALUE    = 32'hC0DE_0001
) (
  input  logic               wb_clk,
  input  logic               wb_rst_n,
  wb_slave_regfile_if.slave  wb,
  output logic [WB_DW-1:0]   txn_count
);

  wb_state_e          state, state_d;
  logic [3:0]         cnt, cnt_d;
  logic               stall_q, stall_d;
  logic               ack_q, ack_d;
  logic               err_q, err_d;
  logic [WB_DW-1:0]   dat_q, dat_d;

  logic [WB_AW-1:0]   adr_q;
  logic               we_q;
  logic [WB_SELW-1:0] sel_q;
  logic [WB_DW-1:0]   wdat_q;

  logic               latch_en;
  logic               wr_en;
  logic               txn_inc;
  logic               req_err;
  logic [WB_DW-1:0]   rdata;
  wb_decode_t         dec;

  logic [WB_DW-1:0]   regs [1:NUM_REGS-1];

  assign wb.wb_dat_o = dat_q;
  assign wb.wb_ack   = ack_q;
  assign wb.wb_err   = err_q;
  assign wb.wb_stall = stall_q;

  wb_slave_decode #(
    .BASE_ADDR (BASE_ADDR),
    .NUM_REGS  (NUM_REGS)
  ) u_decode (
    .adr (adr_q),
    .we  (we_q),
    .dec (dec)
  );

  assign req_err = !dec.hit || dec.misaligned || dec.ro_violation || (sel_q == '0);

  always_comb begin
    rdata = ID_VALUE;
    for (int unsigned i = 1; i < NUM_REGS; i++) begin
      if (32'(dec.idx) == i) rdata = regs[i];
    end
  end

  // RESP spans two edges: the first raises ack/err, the second (ack/err
  // already high) drops them together with stall and returns to IDLE.
  always_comb begin
    state_d  = state;
    cnt_d    = cnt;
    stall_d  = stall_q;
    ack_d    = 1'b0;
    err_d    = 1'b0;
    dat_d    = dat_q;
    latch_en = 1'b0;
    wr_en    = 1'b0;
    txn_inc  = 1'b0;
    unique case (state)
      IDLE: begin
        stall_d = 1'b0;
        if (wb.wb_cyc && wb.wb_stb) begin
          latch_en = 1'b1;
          cnt_d    = 4'(WAIT_STATES);
          stall_d  = 1'b1;
          state_d  = (WAIT_STATES > 0) ? WAIT : RESP;
        end
      end
      WAIT: begin
        if (!wb.wb_cyc) begin
          state_d = IDLE;
          stall_d = 1'b0;
        end else begin
          cnt_d = cnt - 4'd1;
          if (cnt == 4'd1) state_d = RESP;
        end
      end
      RESP: begin
        if (ack_q || err_q || !wb.wb_cyc) begin
          state_d = IDLE;
          stall_d = 1'b0;
        end else if (req_err) begin
          err_d = 1'b1;
        end else begin
          ack_d   = 1'b1;
          txn_inc = 1'b1;
          if (we_q) wr_en = 1'b1;
          else      dat_d = rdata;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      stall_q   <= 1'b0;
      ack_q     <= 1'b0;
      err_q     <= 1'b0;
      dat_q     <= '0;
      txn_count <= '0;
    end else begin
      state   <= state_d;
      cnt     <= cnt_d;
      stall_q <= stall_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      dat_q   <= dat_d;
      if (txn_inc) txn_count <= txn_count + 1'b1;
    end
  end

  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      adr_q  <= '0;
      we_q   <= 1'b0;
      sel_q  <= '0;
      wdat_q <= '0;
    end else if (latch_en) begin
      adr_q  <= wb.wb_adr;
      we_q   <= wb.wb_we;
      sel_q  <= wb.wb_sel;
      wdat_q <= wb.wb_dat_i;
    end
  end

  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      for (int unsigned i = 1; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (wr_en) begin
      for (int unsigned i = 1; i < NUM_REGS; i++) begin
        if (32'(dec.idx) == i) begin
          for (int unsigned b = 0; b < WB_SELW; b++) begin
            if (sel_q[b]) regs[i][8*b +: 8] <= wdat_q[8*b +: 8];
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_wb_slave_regfile.sv
// Randomized self-checking bench for wb_slave_regfile against a behavioural register model.
module tb_wb_slave_regfile;

  localparam logic [31:0] BASE  = 32'h1000_0000;
  localparam int unsigned NREGS = 8;
  localparam int unsigned WS    = 1;
  localparam logic [31:0] ID    = 32'hC0DE_0001;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] txn_count;

  int unsigned checks = 0;
  int unsigned errors = 0;

  logic [31:0] mregs [NREGS];
  logic [31:0] mcount = '0;
  logic [31:0] mdat   = '0;

  wb_slave_regfile_if wb ();

  wb_slave_regfile #(
    .BASE_ADDR   (BASE),
    .NUM_REGS    (NREGS),
    .WAIT_STATES (WS),
    .ID_VALUE    (ID)
  ) dut (
    .wb_clk    (clk),
    .wb_rst_n  (rst_n),
    .wb        (wb),
    .txn_count (txn_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic model_err(input logic we, input logic [31:0] adr, input logic [3:0] sel);
    logic [31:0] off;
    off = adr - BASE;
    return (off >= 4 * NREGS) || (adr % 4 != 0) || (sel == 4'd0) || (we && off < 4);
  endfunction

  task automatic model_apply(input logic we, input logic [31:0] adr, input logic [3:0] sel,
                             input logic [31:0] dat, output logic exp_err);
    logic [31:0] idx;
    exp_err = model_err(we, adr, sel);
    if (!exp_err) begin
      mcount++;
      idx = (adr - BASE) / 4;
      if (we) begin
        for (int b = 0; b < 4; b++)
          if (sel[b]) mregs[idx][8*b +: 8] = dat[8*b +: 8];
      end else begin
        mdat = (idx == 0) ? ID : mregs[idx];
      end
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NREGS; i++) mregs[i] = '0;
    mcount = '0;
    mdat   = '0;
  endtask

  // Request is held on the bus through the stall window until the response arrives.
  task automatic xfer(input string tag, input logic we, input logic [31:0] adr,
                      input logic [3:0] sel, input logic [31:0] dat);
    logic        exp_err, got_ack, got_err;
    logic [31:0] got_dat;
    int          lat;
    model_apply(we, adr, sel, dat, exp_err);
    @(negedge clk);
    wb.wb_cyc = 1'b1; wb.wb_stb = 1'b1; wb.wb_we = we;
    wb.wb_adr = adr;  wb.wb_sel = sel;  wb.wb_dat_i = dat;
    for (int n = 0; n < 20 && wb.wb_stall; n++) @(negedge clk);
    @(posedge clk);
    lat = 0; got_ack = 1'b0; got_err = 1'b0; got_dat = '0;
    while (!(got_ack || got_err) && lat < 40) begin
      @(posedge clk); #1;
      lat++;
      got_ack = wb.wb_ack; got_err = wb.wb_err; got_dat = wb.wb_dat_o;
    end
    wb.wb_cyc = 1'b0; wb.wb_stb = 1'b0;
    check({tag, ".ack"}, 32'(got_ack), 32'(!exp_err));
    check({tag, ".err"}, 32'(got_err), 32'(exp_err));
    check({tag, ".lat"}, 32'(lat), 32'(WS + 1));
    check({tag, ".dat"}, got_dat, mdat);
    @(posedge clk); #1;
    check({tag, ".pulse"}, 32'({wb.wb_ack, wb.wb_err}), 32'd0);
    check({tag, ".stall"}, 32'(wb.wb_stall), 32'd0);
    check({tag, ".count"}, txn_count, mcount);
  endtask

  task automatic check_all_regs(input string tag);
    for (int i = 0; i < NREGS; i++) xfer(tag, 1'b0, BASE + 32'(4 * i), 4'hF, '0);
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] k;
    k = 32'($urandom_range(0, NREGS - 1));
    case ($urandom_range(0, 11))
      8:       return BASE + 32'(4 * NREGS) + 32'(4 * $urandom_range(0, 15));
      9:       return BASE + 4 * k + 32'($urandom_range(1, 3));
      10:      return BASE - 32'(4 * $urandom_range(1, 4));
      11:      return $urandom;
      default: return BASE + 4 * k;
    endcase
  endfunction

  initial begin
    wb.wb_cyc = 1'b0; wb.wb_stb = 1'b0; wb.wb_we = 1'b0;
    wb.wb_sel = '0;   wb.wb_adr = '0;   wb.wb_dat_i = '0;
    model_reset();

    repeat (3) @(negedge clk);
    check("rst.stall", 32'(wb.wb_stall), 32'd0);
    check("rst.ack",   32'(wb.wb_ack),   32'd0);
    check("rst.err",   32'(wb.wb_err),   32'd0);
    check("rst.dat",   wb.wb_dat_o,      32'd0);
    check("rst.count", txn_count,        32'd0);
    rst_n = 1'b1;

    xfer("id_read", 1'b0, BASE, 4'hF, '0);
    check("id_value", wb.wb_dat_o, 32'hC0DE_0001);

    xfer("bytewr", 1'b1, BASE + 32'h8, 4'b0101, 32'hAABB_CCDD);
    xfer("byterd", 1'b0, BASE + 32'h8, 4'hF, '0);
    check("byterd_const", wb.wb_dat_o, 32'h00BB_00DD);

    xfer("err_ro",    1'b1, BASE,              4'hF, 32'hFFFF_FFFF);
    xfer("err_range", 1'b0, BASE + 32'h20,     4'hF, '0);
    xfer("err_align", 1'b0, BASE + 32'h6,      4'hF, '0);
    xfer("err_sel0",  1'b1, BASE + 32'h8,      4'h0, 32'h5555_5555);
    xfer("err_below", 1'b0, BASE - 32'h4,      4'hF, '0);
    xfer("after_err", 1'b0, BASE + 32'h8,      4'hF, '0);

    // Abort: cyc dropped while the write waits; nothing may be committed.
    @(negedge clk);
    wb.wb_cyc = 1'b1; wb.wb_stb = 1'b1; wb.wb_we = 1'b1;
    wb.wb_adr = BASE + 32'h4; wb.wb_sel = 4'hF; wb.wb_dat_i = 32'h1234_5678;
    @(posedge clk);
    @(negedge clk);
    wb.wb_cyc = 1'b0; wb.wb_stb = 1'b0;
    for (int n = 0; n < 4; n++) begin
      @(negedge clk);
      check("abort.resp", 32'({wb.wb_ack, wb.wb_err}), 32'd0);
    end
    check("abort.stall", 32'(wb.wb_stall), 32'd0);
    check("abort.count", txn_count, mcount);
    xfer("abort_rd", 1'b0, BASE + 32'h4, 4'hF, '0);

    for (int t = 0; t < 80; t++) begin
      logic        we;
      logic [3:0]  sel;
      we  = 1'($urandom_range(0, 1));
      sel = 4'($urandom_range(0, 15));
      xfer("rand", we, rand_addr(), sel, $urandom);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    check_all_regs("final_rd");

    // Async reset in the middle of a write's wait state.
    for (int i = 1; i < NREGS; i++) xfer("prefill", 1'b1, BASE + 32'(4 * i), 4'hF, $urandom | 32'h1);
    @(negedge clk);
    wb.wb_cyc = 1'b1; wb.wb_stb = 1'b1; wb.wb_we = 1'b1;
    wb.wb_adr = BASE + 32'hC; wb.wb_sel = 4'hF; wb.wb_dat_i = 32'hDEAD_BEEF;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check("arst.stall", 32'(wb.wb_stall), 32'd0);
    check("arst.ack",   32'(wb.wb_ack),   32'd0);
    check("arst.err",   32'(wb.wb_err),   32'd0);
    check("arst.dat",   wb.wb_dat_o,      32'd0);
    check("arst.count", txn_count,        32'd0);
    wb.wb_cyc = 1'b0; wb.wb_stb = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    xfer("post_rst_id", 1'b0, BASE, 4'hF, '0);
    check("post_rst_cnt", txn_count, 32'd1);
    check_all_regs("post_rst_rd");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
